// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - object handshake and VGA plot bundle for frame_scheduler
interface frame_scheduler_if #(
  parameter int NUM_OBJ = 4
);
  logic [NUM_OBJ-1:0]   obj_start;
  logic [NUM_OBJ-1:0]   obj_done;
  logic [8*NUM_OBJ-1:0] obj_x;
  logic [7*NUM_OBJ-1:0] obj_y;
  logic [3*NUM_OBJ-1:0] obj_color;
  logic [NUM_OBJ-1:0]   obj_wren;
  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic [2:0]           vga_color;
  logic                 vga_plot;

  // Scheduler side: drives starts and the plot port, listens to the objects.
  modport master (
    output obj_start,
    input  obj_done, obj_x, obj_y, obj_color, obj_wren,
    output vga_x, vga_y, vga_color, vga_plot
  );

  // Object / adapter side.
  modport slave (
    input  obj_start,
    output obj_done, obj_x, obj_y, obj_color, obj_wren,
    input  vga_x, vga_y, vga_color, vga_plot
  );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame object sequencer and pixel-write arbiter
module frame_scheduler #(
  parameter int NUM_OBJ        = 4,
  parameter int FRAME_TICKS    = 833333,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  frame_scheduler_if.master bus,
  output logic              busy,
  output logic [7:0]        frame_count,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_WAIT_CLEAR,
    S_NEXT
  } state_t;

  state_t             state, state_n;
  logic [SW-1:0]      slot, slot_n;
  logic [NUM_OBJ-1:0] start_q, start_n;
  logic [WW-1:0]      wait_cnt, wait_n;
  logic [7:0]         fc_n;
  logic               terr_n, pend, pend_n, ovr_n;
  logic [TW-1:0]      tick_cnt;
  logic               frame_tick;

  int                 sel;
  logic [7:0]         cur_x;
  logic [6:0]         cur_y;
  logic [2:0]         cur_c;
  logic               cur_wren, cur_done, plot_n;
  logic [7:0]         vx_q;
  logic [6:0]         vy_q;
  logic [2:0]         vc_q;
  logic               plot_q;

  assign frame_tick    = (tick_cnt == TW'(FRAME_TICKS - 1));
  assign busy          = (state != S_IDLE);
  assign bus.obj_start = start_q;
  assign bus.vga_x     = vx_q;
  assign bus.vga_y     = vy_q;
  assign bus.vga_color = vc_q;
  assign bus.vga_plot  = plot_q;

  // Only the granted slot's write port is visible to the plot path.
  assign sel      = int'(slot);
  assign cur_x    = bus.obj_x[8*sel +: 8];
  assign cur_y    = bus.obj_y[7*sel +: 7];
  assign cur_c    = bus.obj_color[3*sel +: 3];
  assign cur_wren = bus.obj_wren[slot];
  assign cur_done = bus.obj_done[slot];
  assign plot_n   = (state == S_WAIT_DONE) && cur_wren &&
                    (cur_x <= 8'd159) && (cur_y <= 7'd119);

  // Free-running frame tick counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         tick_cnt <= '0;
    else if (frame_tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + TW'(1);
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      slot        <= '0;
      start_q     <= '0;
      wait_cnt    <= '0;
      frame_count <= '0;
      timeout_err <= 1'b0;
      pend        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      start_q     <= start_n;
      wait_cnt    <= wait_n;
      frame_count <= fc_n;
      timeout_err <= terr_n;
      pend        <= pend_n;
      overrun     <= ovr_n;
    end
  end

  // Next-state logic: tick bookkeeping, then the per-slot start/done walk.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    start_n = start_q;
    wait_n  = wait_cnt;
    fc_n    = frame_count;
    terr_n  = timeout_err;
    pend_n  = pend;
    ovr_n   = overrun;

    // A tick arriving with one already queued is lost.
    if (frame_tick && pend)       ovr_n  = 1'b1;
    else if (frame_tick && busy)  pend_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (frame_tick || pend) begin
          pend_n = 1'b0;
          if (enable) begin
            slot_n  = '0;
            state_n = S_START;
          end
        end
      end
      S_START: begin
        start_n       = '0;
        start_n[slot] = 1'b1;
        wait_n        = '0;
        state_n       = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (cur_done) begin
          start_n = '0;
          wait_n  = '0;
          state_n = S_WAIT_CLEAR;
        end else if (wait_cnt == WW'(TIMEOUT_CYCLES)) begin
          terr_n  = 1'b1;
          start_n = '0;
          state_n = S_NEXT;
        end else begin
          wait_n = wait_cnt + WW'(1);
        end
      end
      S_WAIT_CLEAR: begin
        if (!cur_done) begin
          state_n = S_NEXT;
        end else if (wait_cnt == WW'(TIMEOUT_CYCLES)) begin
          terr_n  = 1'b1;
          state_n = S_NEXT;
        end else begin
          wait_n = wait_cnt + WW'(1);
        end
      end
      S_NEXT: begin
        if (slot == SW'(NUM_OBJ - 1)) begin
          fc_n    = frame_count + 8'd1;
          state_n = S_IDLE;
        end else begin
          slot_n  = slot + SW'(1);
          state_n = S_START;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered plot port; coordinates are held between strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      vx_q   <= '0;
      vy_q   <= '0;
      vc_q   <= '0;
    end else begin
      plot_q <= plot_n;
      if (plot_n) begin
        vx_q <= cur_x;
        vy_q <= cur_y;
        vc_q <= cur_c;
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;
  localparam int N  = 4;
  localparam int FT = 200;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       busy;
  logic [7:0] frame_count;
  logic       timeout_err, overrun;

  frame_scheduler_if #(.NUM_OBJ(N)) bus ();

  frame_scheduler #(.NUM_OBJ(N), .FRAME_TICKS(FT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .bus(bus),
    .busy(busy), .frame_count(frame_count),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Clock edges since reset release; matches the position within the frame period.
  always @(posedge clk) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub behaviour and write script
  int         done_dly[N];
  bit         stuck[N];
  int         nw;
  int         wg[8], woff[8], ws[8];
  logic [7:0] wx[8];
  logic [6:0] wy[8];
  logic [2:0] wc[8];

  // Model state
  int          rise_c[N], fall_c[N];
  int          last_fall, busy_rise_c, exp_slot, frames;
  bit          last_to;
  logic [N-1:0] prev_start;
  logic        prev_busy;
  logic        exp_plot;
  logic [7:0]  ex;
  logic [6:0]  ey;
  logic [2:0]  ec;
  logic [17:0] pix[$];

  // Stubs, scoreboard and per-cycle compare, all on the falling edge.
  initial begin
    bus.obj_done = '0; bus.obj_wren = '0;
    bus.obj_x = '0; bus.obj_y = '0; bus.obj_color = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_start = '0; prev_busy = 1'b0; exp_slot = 0; frames = 0;
        last_to = 1'b0; last_fall = -1000; busy_rise_c = -1000;
        exp_plot = 1'b0; ex = '0; ey = '0; ec = '0;
        pix.delete();
        for (int i = 0; i < N; i++) begin rise_c[i] = -1000; fall_c[i] = -1000; end
        bus.obj_done = '0; bus.obj_wren = '0;
      end else begin
        chk("vga_plot", bus.vga_plot, exp_plot);
        if (exp_plot) begin
          chk("vga_x", bus.vga_x, ex);
          chk("vga_y", bus.vga_y, ey);
          chk("vga_color", bus.vga_color, ec);
        end
        if (bus.vga_plot) pix.push_back({bus.vga_x, bus.vga_y, bus.vga_color});
        chk("start_onehot", $onehot0(bus.obj_start), 1);
        if (!busy) chk("start_idle", bus.obj_start, 0);

        if (busy && !prev_busy) busy_rise_c = cyc;
        if (!busy && prev_busy) begin
          chk("frame_count_end", frame_count, frames % 256);
          chk("idle_after_last", cyc - last_fall, last_to ? 1 : 4);
        end
        for (int i = 0; i < N; i++) begin
          if (bus.obj_start[i] && !prev_start[i]) begin
            chk("start_order", i, exp_slot);
            if (i == 0) chk("start_after_busy", cyc - busy_rise_c, 1);
            else        chk("start_gap", cyc - last_fall, last_to ? 2 : 5);
            rise_c[i] = cyc;
            exp_slot = (i + 1) % N;
          end
          if (!bus.obj_start[i] && prev_start[i]) begin
            chk("start_len", cyc - rise_c[i], stuck[i] ? TO + 1 : done_dly[i] + 1);
            fall_c[i] = cyc; last_fall = cyc; last_to = stuck[i];
            if (i == N - 1) frames++;
          end
        end
        prev_start = bus.obj_start;
        prev_busy = busy;

        for (int i = 0; i < N; i++) begin
          if (stuck[i])                bus.obj_done[i] = 1'b0;
          else if (bus.obj_start[i])   bus.obj_done[i] = (cyc - rise_c[i] >= done_dly[i]);
          else if (bus.obj_done[i] && (cyc - fall_c[i] >= 2)) bus.obj_done[i] = 1'b0;
        end
        bus.obj_wren = '0;
        for (int k = 0; k < nw; k++) begin
          if (cyc - rise_c[wg[k]] == woff[k]) begin
            bus.obj_wren[ws[k]] = 1'b1;
            bus.obj_x[8*ws[k] +: 8] = wx[k];
            bus.obj_y[7*ws[k] +: 7] = wy[k];
            bus.obj_color[3*ws[k] +: 3] = wc[k];
          end
        end

        exp_plot = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (bus.obj_start[i] && bus.obj_wren[i] &&
              bus.obj_x[8*i +: 8] <= 8'd159 && bus.obj_y[7*i +: 7] <= 7'd119) begin
            exp_plot = 1'b1;
            ex = bus.obj_x[8*i +: 8]; ey = bus.obj_y[7*i +: 7]; ec = bus.obj_color[3*i +: 3];
          end
        end
      end
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #1;
    chk("at_cyc", cyc, n);
  endtask

  task automatic set_w(input int k, input int g, input int off, input int s,
                       input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    wg[k] = g; woff[k] = off; ws[k] = s; wx[k] = x; wy[k] = y; wc[k] = c;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
  endtask

  logic [17:0] p;

  initial begin
    for (int i = 0; i < N; i++) begin done_dly[i] = 5; stuck[i] = 1'b0; end
    nw = 0;
    #1;
    chk("rst_start", bus.obj_start, 0);
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overrun", overrun, 0);

    // Normal frames with the write-arbitration script
    set_w(0, 0, 5, 0, 8'd1,   7'd2,   3'd3);
    set_w(1, 0, 6, 0, 8'd50,  7'd50,  3'd1);
    set_w(2, 1, 0, 1, 8'd10,  7'd20,  3'd7);
    set_w(3, 1, 0, 2, 8'd30,  7'd40,  3'd1);
    set_w(4, 1, 1, 1, 8'd160, 7'd5,   3'd4);
    set_w(5, 1, 2, 1, 8'd5,   7'd120, 3'd5);
    set_w(6, 1, 3, 1, 8'd159, 7'd119, 3'd2);
    nw = 7;
    enable = 1'b1;
    release_reset();
    at_cyc(199); chk("a_busy_199", busy, 0);
    at_cyc(200); chk("a_busy_200", busy, 1); chk("a_start_200", bus.obj_start, 0);
    at_cyc(201); chk("a_start_201", bus.obj_start, 4'b0001);
    at_cyc(212); chk("a_start_212", bus.obj_start, 4'b0010);
    at_cyc(243); chk("a_busy_243", busy, 1);
    at_cyc(244);
    chk("a_busy_244", busy, 0);
    chk("a_frame_count", frame_count, 1);
    chk("a_pix_count", pix.size(), 3);
    if (pix.size() == 3) begin
      p = {8'd1, 7'd2, 3'd3};     chk("a_pix0", pix[0], p);
      p = {8'd10, 7'd20, 3'd7};   chk("a_pix1", pix[1], p);
      p = {8'd159, 7'd119, 3'd2}; chk("a_pix2", pix[2], p);
    end
    at_cyc(399); chk("a_busy_399", busy, 0);
    at_cyc(400); chk("a_busy_400", busy, 1);
    at_cyc(414); chk("a_start_414", bus.obj_start, 4'b0010); chk("a_fc_414", frame_count, 1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_start", bus.obj_start, 0);
    chk("mid_rst_plot", bus.vga_plot, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    chk("mid_rst_busy", busy, 0);
    release_reset();
    at_cyc(199); chk("r_busy_199", busy, 0);
    at_cyc(200); chk("r_busy_200", busy, 1);
    at_cyc(201); chk("r_start_201", bus.obj_start, 4'b0001);

    // Slot 2 never answers; first tick is skipped with enable low
    resetn = 1'b0;
    nw = 0; stuck[2] = 1'b1; enable = 1'b0;
    release_reset();
    at_cyc(250); enable = 1'b1;
    at_cyc(300); chk("b_busy_300", busy, 0);
    at_cyc(401); chk("b_start_401", bus.obj_start, 4'b0001);
    at_cyc(423); chk("b_start_423", bus.obj_start, 4'b0100);
    at_cyc(678); chk("b_start_678", bus.obj_start, 4'b0100); chk("b_terr_678", timeout_err, 0);
    at_cyc(679); chk("b_start_679", bus.obj_start, 0); chk("b_terr_679", timeout_err, 1);
    at_cyc(681); chk("b_start_681", bus.obj_start, 4'b1000);
    at_cyc(690); chk("b_busy_690", busy, 1);
    at_cyc(691); chk("b_busy_691", busy, 0); chk("b_frame_count", frame_count, 1);
    at_cyc(692); chk("b_busy_692", busy, 1);

    // Slow objects: frames longer than the tick period
    resetn = 1'b0;
    stuck[2] = 1'b0;
    for (int i = 0; i < N; i++) done_dly[i] = 107;
    release_reset();
    at_cyc(599); chk("c_overrun_599", overrun, 0);
    at_cyc(600); chk("c_overrun_600", overrun, 1);
    at_cyc(651); chk("c_busy_651", busy, 1);
    at_cyc(652); chk("c_busy_652", busy, 0); chk("c_frame_count", frame_count, 1);
    at_cyc(653); chk("c_busy_653", busy, 1);
    at_cyc(654); chk("c_start_654", bus.obj_start, 4'b0001);
    chk("c_timeout_err", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
